// File: rtl/reaction_session_fsm.sv
// Multi-round reaction timer: random wait, lit, timed press; keeps last/best result in packed BCD.
// States: IDLE, DEBOUNCE, WAIT, MEASURE, EARLY, RESULT, SUMMARY. Define REACTION_PENALTY_EN to count early presses as rounds.
module reaction_session_fsm #(
    parameter int TICK_DIV     = 40,
    parameter int DIGITS       = 6,
    parameter int ROUNDS       = 4,
    parameter int DEBOUNCE_BIT = 19,
    parameter int WAIT_SHIFT   = 11,
    parameter int TIMEOUT_BIT  = 24
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_btn,
    output logic                           o_lit,
    output logic                           o_miss,
    output logic [2:0]                     o_dst,
    output logic [4*DIGITS-1:0]            o_measured,
    output logic [4*DIGITS-1:0]            o_best,
    output logic [$clog2(ROUNDS+1)-1:0]    o_round,
    output logic                           o_done,
    output logic [5:0]                     o_shrnd
);

    localparam int BW  = 4 * DIGITS;
    localparam int RW  = $clog2(ROUNDS + 1);
    localparam int CW0 = (DEBOUNCE_BIT > WAIT_SHIFT + 15) ? DEBOUNCE_BIT : WAIT_SHIFT + 15;
    localparam int CW  = ((CW0 > TIMEOUT_BIT) ? CW0 : TIMEOUT_BIT) + 1;
    localparam int SW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [BW-1:0] ALL_F = '1;
    localparam logic [BW-1:0] ALL_9 = {DIGITS{4'h9}};

    typedef enum logic [2:0] {
        S_IDLE, S_DEBOUNCE, S_WAIT, S_MEASURE, S_EARLY, S_RESULT, S_SUMMARY
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   sub_q, sub_d;
    logic [15:0]     rnd_q, rnd_d;
    logic            btn_q;
    logic [RW-1:0]   round_q, round_d;
    logic [BW-1:0]   bcd_q, bcd_d, bcd_inc;
    logic [BW-1:0]   meas_q, meas_d;
    logic [BW-1:0]   best_q, best_d;
    logic            clicked;

    assign clicked = i_btn & ~btn_q;

    // Ripple BCD increment that sticks at all nines instead of wrapping.
    always_comb begin
        logic carry;
        bcd_inc = bcd_q;
        carry   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (bcd_q[4*i +: 4] == 4'h9) begin
                    bcd_inc[4*i +: 4] = 4'h0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'h1;
                    carry = 1'b0;
                end
            end
        end
        if (bcd_q == ALL_9) bcd_inc = bcd_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        rnd_d   = rnd_q;
        round_d = round_q;
        bcd_d   = bcd_q;
        meas_d  = meas_q;
        best_d  = best_q;
        case (state_q)
            S_IDLE: begin
                rnd_d = {rnd_q[14:0], ((rnd_q[15] ^ rnd_q[13]) ~^ rnd_q[12]) ^ rnd_q[10]};
                cnt_d = '0;
                if (clicked) state_d = S_DEBOUNCE;
            end
            S_DEBOUNCE: begin
                if (cnt_q[DEBOUNCE_BIT]) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (clicked) begin
                    state_d = S_EARLY;
                    cnt_d   = '0;
`ifdef REACTION_PENALTY_EN
                    meas_d  = ALL_9;
                    round_d = round_q + RW'(1);
                    if (best_q == ALL_F) best_d = ALL_9;
`endif
                end else if (cnt_q[WAIT_SHIFT+15:WAIT_SHIFT] >= rnd_q) begin
                    state_d = S_MEASURE;
                    cnt_d   = '0;
                    bcd_d   = '0;
                    sub_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_MEASURE: begin
                cnt_d = cnt_q + CW'(1);
                if (sub_q == SW'(TICK_DIV - 1)) begin
                    sub_d = '0;
                    bcd_d = bcd_inc;
                end else begin
                    sub_d = sub_q + SW'(1);
                end
                if (cnt_q[TIMEOUT_BIT]) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    meas_d  = ALL_F;
                end else if (clicked) begin
                    state_d = S_RESULT;
                    cnt_d   = '0;
                    meas_d  = bcd_q;
                    round_d = round_q + RW'(1);
                    if (bcd_q < best_q) best_d = bcd_q;
                end
            end
            S_EARLY: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q[TIMEOUT_BIT]) begin
                    cnt_d = '0;
`ifdef REACTION_PENALTY_EN
                    state_d = (round_q == RW'(ROUNDS)) ? S_SUMMARY : S_IDLE;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            S_RESULT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q[TIMEOUT_BIT] || clicked) begin
                    cnt_d   = '0;
                    state_d = (round_q == RW'(ROUNDS)) ? S_SUMMARY : S_IDLE;
                end
            end
            S_SUMMARY: begin
                cnt_d = '0;
                if (clicked) begin
                    round_d = '0;
                    best_d  = ALL_F;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sub_q   <= '0;
            rnd_q   <= 16'hDEAD;
            btn_q   <= 1'b0;
            round_q <= '0;
            bcd_q   <= '0;
            meas_q  <= ALL_F;
            best_q  <= ALL_F;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            rnd_q   <= rnd_d;
            btn_q   <= i_btn;
            round_q <= round_d;
            bcd_q   <= bcd_d;
            meas_q  <= meas_d;
            best_q  <= best_d;
        end
    end

    always_comb begin
        o_dst = 3'b000;
        case (state_q)
            S_DEBOUNCE, S_WAIT: o_dst = 3'b001;
            S_MEASURE:          o_dst = 3'b010;
            S_EARLY:            o_dst = 3'b011;
            S_RESULT:           o_dst = 3'b110;
            S_SUMMARY:          o_dst = 3'b111;
            default:            o_dst = 3'b000;
        endcase
    end

    assign o_lit      = (state_q == S_MEASURE);
    assign o_miss     = (state_q == S_EARLY);
    assign o_done     = (state_q == S_SUMMARY);
    assign o_measured = meas_q;
    assign o_best     = best_q;
    assign o_round    = round_q;
    assign o_shrnd    = rnd_q[5:0];

endmodule

// File: tb/tb_reaction_session_fsm.sv
// Directed bench for reaction_session_fsm: small-parameter session, early press, timeout, reset, saturation.
module tb_reaction_session_fsm;

    localparam int TD = 4, DG = 3, RN = 2, DB = 3, WS = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, btn_a = 1'b0;
    logic        lit_a, miss_a, done_a;
    logic [2:0]  dst_a;
    logic [11:0] meas_a, best_a;
    logic [1:0]  round_a;
    logic [5:0]  shrnd_a;

    logic        rst_b = 1'b1, btn_b = 1'b0;
    logic        lit_b, miss_b, done_b;
    logic [2:0]  dst_b;
    logic [11:0] meas_b, best_b;
    logic [1:0]  round_b;
    logic [5:0]  shrnd_b;

    reaction_session_fsm #(.TICK_DIV(TD), .DIGITS(DG), .ROUNDS(RN), .DEBOUNCE_BIT(DB),
                           .WAIT_SHIFT(WS), .TIMEOUT_BIT(8)) dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_btn(btn_a), .o_lit(lit_a), .o_miss(miss_a),
        .o_dst(dst_a), .o_measured(meas_a), .o_best(best_a), .o_round(round_a),
        .o_done(done_a), .o_shrnd(shrnd_a));

    reaction_session_fsm #(.TICK_DIV(TD), .DIGITS(DG), .ROUNDS(RN), .DEBOUNCE_BIT(DB),
                           .WAIT_SHIFT(WS), .TIMEOUT_BIT(13)) dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_btn(btn_b), .o_lit(lit_b), .o_miss(miss_b),
        .o_dst(dst_b), .o_measured(meas_b), .o_best(best_b), .o_round(round_b),
        .o_done(done_b), .o_shrnd(shrnd_b));

    int nchk = 0;
    int nerr = 0;
    int last_k;

`ifdef REACTION_PENALTY_EN
    localparam logic [1:0]  EARLY_ROUND = 2'd1;
    localparam logic [11:0] EARLY_MEAS  = 12'h999;
`else
    localparam logic [1:0]  EARLY_ROUND = 2'd0;
    localparam logic [11:0] EARLY_MEAS  = 12'hFFF;
`endif

    function automatic logic [15:0] lfsr(input logic [15:0] r);
        return {r[14:0], ((r[15] ^ r[13]) ~^ r[12]) ^ r[10]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic click_a();
        btn_a = 1'b1;
        @(negedge clk);
        btn_a = 1'b0;
    endtask

    // Idles in IDLE until the frozen LFSR value is below 256, then presses.
    task automatic press_a(input logic [15:0] s, output logic [15:0] fr);
        logic [15:0] r;
        int k;
        r = lfsr(s);
        k = 1;
        while ((k < 2 || r >= 16'd256) && k < 20000) begin
            r = lfsr(r);
            k++;
        end
        last_k = k;
        repeat (k - 1) @(negedge clk);
        click_a();
        fr = r;
        chk("press_dst", 32'(dst_a), 32'd1);
        chk("press_shrnd", 32'(shrnd_a), 32'(r[5:0]));
    endtask

    task automatic wait_lit_a(input logic [15:0] r);
        int n;
        n = 0;
        while (!lit_a && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_len", 32'(n), 32'(10 + int'(r)));
        chk("measure_dst", 32'(dst_a), 32'd2);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1);
    end

    initial begin
        logic [15:0] fr1, fr2, fr3, fr4, frb;
        int n;

        // Reset state
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        chk("rst_meas", 32'(meas_a), 32'hFFF);
        chk("rst_best", 32'(best_a), 32'hFFF);
        chk("rst_round", 32'(round_a), 32'd0);
        chk("rst_dst", 32'(dst_a), 32'd0);
        chk("rst_lit", 32'(lit_a), 32'd0);
        chk("rst_shrnd", 32'(shrnd_a), 32'h2D);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_b_meas", 32'(meas_b), 32'hFFF);

        // Round 1: click on MEASURE cycle 150 -> 37
        press_a(16'hDEAD, fr1);
        n = last_k;
        wait_lit_a(fr1);
        repeat (150) @(negedge clk);
        click_a();
        chk("r1_meas", 32'(meas_a), 32'h037);
        chk("r1_best", 32'(best_a), 32'h037);
        chk("r1_round", 32'(round_a), 32'd1);
        chk("r1_dst", 32'(dst_a), 32'h6);
        chk("r1_lit", 32'(lit_a), 32'd0);
        @(negedge clk);
        click_a();
        chk("r1_idle", 32'(dst_a), 32'd0);

        // Timeout round: no press for 256 cycles
        press_a(fr1, fr2);
        wait_lit_a(fr2);
        repeat (255) @(negedge clk);
        chk("to_still_lit", 32'(lit_a), 32'd1);
        repeat (2) @(negedge clk);
        chk("to_dst", 32'(dst_a), 32'd0);
        chk("to_meas", 32'(meas_a), 32'hFFF);
        chk("to_round", 32'(round_a), 32'd1);
        chk("to_best", 32'(best_a), 32'h037);

        // Round 2: click on cycle 50 -> 12, session complete
        press_a(fr2, fr3);
        wait_lit_a(fr3);
        repeat (50) @(negedge clk);
        click_a();
        chk("r2_meas", 32'(meas_a), 32'h012);
        chk("r2_best", 32'(best_a), 32'h012);
        chk("r2_round", 32'(round_a), 32'd2);
        chk("r2_dst", 32'(dst_a), 32'h6);
        @(negedge clk);
        click_a();
        chk("sum_dst", 32'(dst_a), 32'h7);
        chk("sum_done", 32'(done_a), 32'd1);
        chk("sum_best", 32'(best_a), 32'h012);
        repeat (300) @(negedge clk);
        chk("sum_hold", 32'(dst_a), 32'h7);
        click_a();
        chk("sum_exit_dst", 32'(dst_a), 32'd0);
        chk("sum_exit_round", 32'(round_a), 32'd0);
        chk("sum_exit_best", 32'(best_a), 32'hFFF);
        chk("sum_exit_done", 32'(done_a), 32'd0);
        chk("sum_exit_meas", 32'(meas_a), 32'h012);

        // Reset during MEASURE
        press_a(fr3, fr4);
        wait_lit_a(fr4);
        repeat (10) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        chk("mrst_dst", 32'(dst_a), 32'd0);
        chk("mrst_lit", 32'(lit_a), 32'd0);
        chk("mrst_meas", 32'(meas_a), 32'hFFF);
        chk("mrst_round", 32'(round_a), 32'd0);
        chk("mrst_shrnd", 32'(shrnd_a), 32'h2D);

        // Early press on first WAIT cycle
        press_a(16'hDEAD, frb);
        repeat (9) @(negedge clk);
        chk("early_pre_dst", 32'(dst_a), 32'd1);
        click_a();
        chk("early_miss", 32'(miss_a), 32'd1);
        chk("early_dst", 32'(dst_a), 32'h3);
        chk("early_lit", 32'(lit_a), 32'd0);
        chk("early_round", 32'(round_a), 32'(EARLY_ROUND));
        chk("early_meas", 32'(meas_a), 32'(EARLY_MEAS));
        repeat (255) @(negedge clk);
        chk("early_hold", 32'(dst_a), 32'h3);
        repeat (2) @(negedge clk);
        chk("early_exit_dst", 32'(dst_a), 32'd0);
        chk("early_exit_miss", 32'(miss_a), 32'd0);
        chk("early_exit_round", 32'(round_a), 32'(EARLY_ROUND));
        chk("early_exit_best", 32'(best_a), 32'(EARLY_MEAS));

        // Saturation on the long-timeout instance: click at cycle 4000
        rst_b = 1'b0;
        repeat (n - 1) @(negedge clk);
        btn_b = 1'b1;
        @(negedge clk);
        btn_b = 1'b0;
        n = 0;
        while (!lit_b && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("sat_wait_len", 32'(n), 32'(10 + int'(fr1)));
        repeat (4000) @(negedge clk);
        chk("sat_still_lit", 32'(lit_b), 32'd1);
        btn_b = 1'b1;
        @(negedge clk);
        btn_b = 1'b0;
        chk("sat_meas", 32'(meas_b), 32'h999);
        chk("sat_best", 32'(best_b), 32'h999);
        chk("sat_round", 32'(round_b), 32'd1);
        chk("sat_dst", 32'(dst_b), 32'h6);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
